// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier: FSM states,
// Booth recoding opcodes and operand extension.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes are the {q0, q(-1)} pair; 2'b11 also means no operation.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam int MAX_WIDTH = 32;

  // Extends a width-bit value (right-aligned in a MAX_WIDTH container) by at
  // least one bit, filling with the sign bit in signed mode and zeros otherwise.
  function automatic logic [MAX_WIDTH:0] ext_operand(input logic [MAX_WIDTH-1:0] value,
                                                     input logic signed_mode,
                                                     input int width);
    logic fill;
    logic [MAX_WIDTH:0] ext;
    fill = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == width - 1) fill = signed_mode & value[i];
    end
    ext = {(MAX_WIDTH+1){fill}};
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) ext[i] = value[i];
    end
    return ext;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// then an arithmetic right shift of the {acc, q, q_m1} chain.
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0] acc,
  input  logic        [WIDTH:0] q,
  input  logic                  q_m1,
  input  logic signed [WIDTH:0] m,
  output logic signed [WIDTH:0] acc_next,
  output logic        [WIDTH:0] q_next,
  output logic                  q_m1_next
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    case ({q[0], q_m1})
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      BOOTH_NOP: sum = acc;
      default:   sum = acc;
    endcase
    acc_next  = sum >>> 1;
    q_next    = {sum[0], q[WIDTH:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_mult_booth.sv
// Parametrised multi-cycle Booth multiplier with start/ready/done handshake,
// signed or unsigned per operation, and a synchronous abort.
module seq_mult_booth
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 abort,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t                state;
  logic signed [WIDTH:0] acc;
  logic signed [WIDTH:0] mcand;
  logic        [WIDTH:0] q;
  logic                  q_m1;
  logic [CNT_W-1:0]      cnt;

  logic [MAX_WIDTH-1:0]  mplier_w, mcand_w;
  logic [MAX_WIDTH:0]    mplier_x, mcand_x;
  logic                  unused_ext;

  logic signed [WIDTH:0] acc_next;
  logic        [WIDTH:0] q_next;
  logic                  q_m1_next;

  always_comb begin
    mplier_w = '0;
    mcand_w  = '0;
    mplier_w[WIDTH-1:0] = multiplier;
    mcand_w[WIDTH-1:0]  = multiplicand;
    mplier_x = ext_operand(mplier_w, signed_mode, WIDTH);
    mcand_x  = ext_operand(mcand_w, signed_mode, WIDTH);
  end

  assign unused_ext = ^{mplier_x, mcand_x};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .m         (mcand),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= mcand_x[WIDTH:0];
            q     <= mplier_x[WIDTH:0];
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_INIT;
            ready <= 1'b0;
            state <= CALC;
          end else begin
            ready <= 1'b1;
          end
        end
        CALC: begin
          // Abort wins over the final step, so product is never touched here.
          if (abort) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            acc  <= acc_next;
            q    <= q_next;
            q_m1 <= q_m1_next;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_LAST) begin
              product <= {acc_next[WIDTH-2:0], q_next};
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
